pc_sequencer: RTL

- Next-generation program counter for the MIPS pipeline fetch stage, replacing the single-register PC.
- Adds a debug-controlled execution state machine: free run, single-step, step-N and halt/resume.
- Adds prioritised next-PC selection (exception vector, taken branch/jump, sequential) and a configurable reset vector.
- Sits between the next-PC mux logic and instruction memory; the debug unit drives the mode and step controls.

---
 rtl/pc_sequencer.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program counter for the MIPS fetch stage with a debug-controlled execution
// state machine (free run, single-step, step-N, halt/resume). It sits between
// the next-PC mux logic and instruction memory.
//
// All state updates happen on the FALLING edge of i_clk. i_reset is
// synchronous and active-high, and it overrides every other input.
//
// Next-PC priority:
//   exception  -> EXC_VECTOR
//   redirect   -> i_target
//   otherwise  -> o_pc + 4
//
// Optional feature (compile-time macro PC_ALIGN_CHECK_EN):
//   When defined, a redirect whose target has i_target[1:0] != 0 is rejected.
//   The PC loads EXC_VECTOR, o_fault pulses for one cycle, and the usual
//   exception side effects apply (state -> IDLE, step count cleared).
//   When undefined, o_fault is tied low and targets are loaded verbatim.
//
// Parameters:
//   NBITS        PC width
//   RESET_VECTOR PC value after reset
//   EXC_VECTOR   PC loaded on exception or alignment fault
//   CNTW         width of the step-N counter
//
// Ports:
//   i_clk            clock; state updates on the falling edge
//   i_reset          synchronous active-high reset
//   i_pc_write       hazard-unit permit (0 = stall)
//   i_mode           00 run, 01 single-step, 10 step-N, 11 same as 01
//   i_step           one-cycle step request pulse
//   i_step_count     number of step-N advances, sampled with i_step
//   i_halt           HALT instruction decoded
//   i_resume         leave HALT
//   i_redirect       taken branch or jump
//   i_target         redirect target
//   i_exception      exception request
//   o_pc             current PC
//   o_pc_4           o_pc + 4 (wraps silently)
//   o_pc_8           o_pc + 8 (wraps silently)
//   o_state          00 IDLE, 01 RUN, 10 STEPN, 11 HALT
//   o_advance        registered pulse: the PC was updated at the last edge
//   o_step_remaining step-N advances still to go
//   o_fault          misaligned-target fault pulse (0 unless PC_ALIGN_CHECK_EN)
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int              NBITS        = 32,
    parameter logic [NBITS-1:0] RESET_VECTOR = NBITS'(32'h0000_0000),
    parameter logic [NBITS-1:0] EXC_VECTOR   = NBITS'(32'h0000_0080),
    parameter int              CNTW         = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_pc_write,
    input  logic [1:0]       i_mode,
    input  logic             i_step,
    input  logic [CNTW-1:0]  i_step_count,
    input  logic             i_halt,
    input  logic             i_resume,
    input  logic             i_redirect,
    input  logic [NBITS-1:0] i_target,
    input  logic             i_exception,
    output logic [NBITS-1:0] o_pc,
    output logic [NBITS-1:0] o_pc_4,
    output logic [NBITS-1:0] o_pc_8,
    output logic [1:0]       o_state,
    output logic             o_advance,
    output logic [CNTW-1:0]  o_step_remaining,
    output logic             o_fault
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEPN = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t            state_reg,        state_next;
    logic [NBITS-1:0]  pc_reg,           pc_next;
    logic [CNTW-1:0]   remaining_reg,    remaining_next;
    logic              advance_reg,      advance_next;
    logic              step_pending_reg, step_pending_next;

    // -------------------------------------------------------------------------
    // Decoded controls
    // -------------------------------------------------------------------------
    logic mode_run;
    logic mode_single;
    logic mode_stepn;
    logic step_req;
    logic target_misaligned;

    // Decisions made by the next-state process and consumed by the
    // output/datapath process.
    logic adv_ok;       // state permits an advance and the hazard unit agrees
    logic load_count;   // entering STEPN with a fresh count
    logic fault_take;   // advance would load a misaligned redirect target
    logic exc_take;     // load EXC_VECTOR this edge (exception or fault)

    assign mode_run    = (i_mode == 2'b00);
    assign mode_stepn  = (i_mode == 2'b10);
    // 01 and 11 both mean single-step, so bit 0 alone identifies them.
    assign mode_single = i_mode[0];

    // A single-step request stays live while it waits out a stall.
    assign step_req = i_step | step_pending_reg;

`ifdef PC_ALIGN_CHECK_EN
    assign target_misaligned = i_redirect && (i_target[1:0] != 2'b00);
`else
    assign target_misaligned = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Sequential PC increments (+4 and +8), wrap-around is silent.
    // -------------------------------------------------------------------------
    logic [NBITS-1:0] pc_plus [1:2];

    genvar gi;
    generate
        for (gi = 1; gi <= 2; gi++) begin : g_pc_plus
            assign pc_plus[gi] = pc_reg + NBITS'(4 * gi);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Process 1: state register (plus the datapath registers it owns)
    // -------------------------------------------------------------------------
    always_ff @(negedge i_clk) begin
        if (i_reset) begin
            state_reg        <= ST_IDLE;
            pc_reg           <= RESET_VECTOR;
            remaining_reg    <= '0;
            advance_reg      <= 1'b0;
            step_pending_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            pc_reg           <= pc_next;
            remaining_reg    <= remaining_next;
            advance_reg      <= advance_next;
            step_pending_reg <= step_pending_next;
        end
    end

    // -------------------------------------------------------------------------
    // Process 2: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        adv_ok     = 1'b0;
        load_count = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (mode_run) begin
                    // Enter RUN; the first advance happens on the next edge.
                    state_next = ST_RUN;
                end else if (mode_stepn) begin
                    // A zero count is meaningless and is simply ignored.
                    if (i_step && (i_step_count != '0)) begin
                        state_next = ST_STEPN;
                        load_count = 1'b1;
                    end
                end else if (mode_single) begin
                    adv_ok = step_req && i_pc_write;
                end
            end

            ST_RUN: begin
                if (i_halt) begin
                    // Halt beats a simultaneous redirect: the target is dropped.
                    state_next = ST_HALT;
                end else if (!mode_run) begin
                    state_next = ST_IDLE;
                end else begin
                    adv_ok = i_pc_write;
                end
            end

            ST_STEPN: begin
                // Mode changes are ignored until the count has completed.
                if (i_halt) begin
                    state_next = ST_HALT;
                end else if (i_pc_write) begin
                    adv_ok = 1'b1;
                    // Last advance of the burst (0 is defensive; never loaded).
                    if (remaining_reg <= CNTW'(1)) begin
                        state_next = ST_IDLE;
                    end
                end
            end

            ST_HALT: begin
                // PC frozen; step requests are ignored here.
                if (i_resume) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        fault_take = adv_ok && target_misaligned;
        // An exception acts in every state and ignores stalls.
        exc_take   = i_exception || fault_take;

        if (exc_take) begin
            state_next = ST_IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Process 3: output / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        pc_next           = pc_reg;
        remaining_next    = remaining_reg;
        advance_next      = 1'b0;
        step_pending_next = 1'b0;

        if (exc_take) begin
            pc_next        = EXC_VECTOR;
            remaining_next = '0;
            advance_next   = 1'b1;
        end else begin
            if (adv_ok) begin
                pc_next      = i_redirect ? i_target : pc_plus[1];
                advance_next = 1'b1;
            end

            if (load_count) begin
                remaining_next = i_step_count;
            end else if (adv_ok && (state_reg == ST_STEPN)) begin
                remaining_next = remaining_reg - CNTW'(1);
            end

            // Hold a single-step request across stalls; it is consumed by the
            // advance and dropped if the sequencer leaves single-step IDLE.
            if ((state_reg == ST_IDLE) && mode_single) begin
                step_pending_next = step_req && !i_pc_write;
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic fault_reg;

    always_ff @(negedge i_clk) begin
        if (i_reset) begin
            fault_reg <= 1'b0;
        end else begin
            fault_reg <= fault_take;
        end
    end

    assign o_fault = fault_reg;
`else
    assign o_fault = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_pc             = pc_reg;
    assign o_pc_4           = pc_plus[1];
    assign o_pc_8           = pc_plus[2];
    assign o_state          = state_reg;
    assign o_advance        = advance_reg;
    assign o_step_remaining = remaining_reg;

endmodule
